rr_priority_encoder: RTL
========================

// Module: rr_priority_encoder
// PURPOSE
//  Reverse of the register-select decoders: takes a multi-hot request vector,
//  emits the binary index of each set bit, one per cycle, round-robin order.
//  Valid/ready on both sides; sits between request generators (flag/select
//  lines) and consumers needing binary register/unit indices.
//  Round-robin pointer persists across vectors so no bit position starves.
// PARAMETERS
//  N  4           request vector width; power of two, N >= 2
//  W  $clog2(N)   index width; do not override
// PORTS
//  clk        in   1  clock, all state updates on rising edge
//  reset      in   1  synchronous, active-high reset
//  req_valid  in   1  req_vec presented
//  req_ready  out  1  block idle, accepts a vector this cycle
//  req_vec    in   N  multi-hot request vector
//  enc_valid  out  1  enc_idx/enc_last valid
//  enc_ready  in   1  consumer takes current index
//  enc_idx    out  W  binary index of granted bit
//  enc_last   out  1  enc_idx is the last pending bit of this vector
//  pending    out  N  bits of captured vector not yet emitted
// BEHAVIOUR
//  State: IDLE, BUSY. Registers: state, pending[N], ptr[W], enc_idx, enc_last.
//  Reset (sync, high at edge): state=IDLE, pending=0, ptr=0, enc_valid=0,
//   enc_idx=0, enc_last=0. req_ready=0 while reset high, 1 on first cycle after.
//  req_ready = (state==IDLE) & ~reset; enc_valid = (state==BUSY).
//  IDLE, req_valid & req_ready:
//   - req_vec!=0: pending<=req_vec; enc_idx<=first set bit searching up from
//     ptr, wrapping N-1->0; enc_last<=(popcount(req_vec)==1); state<=BUSY.
//     Latency: enc_valid high the cycle after acceptance.
//   - req_vec==0: accepted and dropped; stay IDLE; no enc_valid.
//  BUSY: req_ready=0; req_valid ignored, req_vec not sampled.
//   - enc_valid & ~enc_ready: enc_idx, enc_last, pending, ptr held stable.
//   - enc_valid & enc_ready: clear pending[enc_idx]; ptr<=enc_idx+1 mod N
//     (natural W-bit wrap). If enc_last: state<=IDLE, enc_valid low next cycle.
//     Else next index (search from enc_idx+1, wrapping, in updated pending)
//     presented next cycle: one index per cycle back-to-back under enc_ready=1.
//   - enc_last = exactly one bit left in pending; computed from next pending.
//  ptr is not reset between vectors; only reset clears it.
//  Each index emitted exactly once per vector; order strictly ascending mod N
//   starting at ptr.
//  Reset mid-BUSY: captured vector discarded, no further enc_valid.
//  enc_idx value when enc_valid=0 is don't-care to consumers, but holds last.
// TESTING (N=4)
//  1 reset, ptr=0, req_vec=4'b1011, enc_ready=1 -> enc_idx 0,1,3 on 3
//    consecutive cycles, enc_last only with 3; req_ready=1 next cycle; ptr=0.
//  2 then req_vec=4'b0110 -> idx 1,2 (ptr=3); then 4'b1001 -> idx 3,0
//    (wrap), enc_last with 0, ptr=1.
//  3 req_vec=4'b0101, enc_ready=0 for 3 cycles after enc_valid -> enc_idx=0,
//    pending=4'b0101 held; enc_ready=1 -> idx 0 then 2.
//  4 req_valid=1, req_vec=0 in IDLE -> enc_valid stays 0, req_ready stays 1.
//  5 req_vec=4'b1111 accepted, reset at second index -> next cycle enc_valid=0,
//    pending=0, ptr=0, req_ready=1.
//  6 req_valid with 4'b1000 pulsed while BUSY on 4'b0011 -> ignored; only
//    idx 0,1 emitted; pending never shows bit 3.

Source files
------------

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder
//   Takes a multi-hot request vector and emits the binary index of each set
//   bit, one per accepted handshake, in ascending order modulo N starting at a
//   round-robin pointer. The pointer survives between vectors, so no bit
//   position is permanently favoured.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req_valid  request vector presented
//   req_ready  idle and able to take a vector this cycle
//   req_vec    multi-hot request vector (N bits)
//   enc_valid  enc_idx / enc_last are valid
//   enc_ready  consumer takes the current index
//   enc_idx    binary index of the granted bit (W bits)
//   enc_last   enc_idx is the last pending bit of the current vector
//   pending    captured bits not yet emitted (N bits)
//
// state | meaning
// IDLE  | waiting for a request vector; req_ready high outside reset
// BUSY  | emitting indices of the captured vector; enc_valid high

module rr_priority_encoder #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_vec,
  output logic         enc_valid,
  input  logic         enc_ready,
  output logic [W-1:0] enc_idx,
  output logic         enc_last,
  output logic [N-1:0] pending
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   pending_nx;
  logic [W-1:0]   ptr, ptr_nx;
  logic [W-1:0]   idx_nx;
  logic           last_nx;
  logic [N-1:0]   pend_clr;
  logic [W-1:0]   idx_inc;

  // First set bit of mask, searching upward from start and wrapping N-1 -> 0.
  // Index arithmetic relies on N being a power of two for the natural wrap.
  function automatic logic [W-1:0] first_set(input logic [N-1:0] mask,
                                             input logic [W-1:0] start);
    logic [W-1:0] idx;
    logic         found;
    first_set = start;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = start + W'(i);
      if (!found && mask[idx]) begin
        first_set = idx;
        found     = 1'b1;
      end
    end
  endfunction

  assign req_ready = (state == IDLE) & ~reset;
  assign enc_valid = (state == BUSY);
  assign idx_inc   = enc_idx + W'(1);

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    ptr_nx     = ptr;
    idx_nx     = enc_idx;
    last_nx    = enc_last;
    pend_clr   = pending;
    pend_clr[enc_idx] = 1'b0;

    case (state)
      IDLE: begin
        // An all-zero vector is accepted and silently dropped.
        if (req_valid && req_ready && (req_vec != '0)) begin
          pending_nx = req_vec;
          idx_nx     = first_set(req_vec, ptr);
          last_nx    = ($countones(req_vec) == 1);
          state_nx   = BUSY;
        end
      end
      BUSY: begin
        if (enc_ready) begin
          pending_nx = pend_clr;
          ptr_nx     = idx_inc;
          if (enc_last) begin
            // enc_idx / enc_last simply hold; they are don't-care while idle.
            state_nx = IDLE;
          end else begin
            idx_nx  = first_set(pend_clr, idx_inc);
            last_nx = ($countones(pend_clr) == 1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= '0;
      ptr      <= '0;
      enc_idx  <= '0;
      enc_last <= 1'b0;
    end else begin
      state    <= state_nx;
      pending  <= pending_nx;
      ptr      <= ptr_nx;
      enc_idx  <= idx_nx;
      enc_last <= last_nx;
    end
  end

endmodule
